// File: rtl/pio_arb_pkg.sv
// Shared types and constants for the PIO bus arbiter.
package pio_arb_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam logic [1:0] PIO_OUT_ADDR = 2'd0;
  localparam int         PIO_OUT_W    = 4;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr_i, with wrap.
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PW-1:0]      rr_ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PW-1:0]      idx_o,
  output logic               any_o
);
  always_comb begin
    int j;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(rr_ptr_i) + k) % NUM_REQ;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = PW'(j);
      end
    end
  end
endmodule

// File: rtl/pio_bus_arbiter.sv
// Round-robin arbiter serialising single read/write commands onto the PIO Avalon-MM slave,
// with a shadow copy of the PIO output register.
module pio_bus_arbiter
  import pio_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_address,
  input  logic [NUM_REQ*DATA_W-1:0]  req_writedata,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         resp_valid,
  output logic [DATA_W-1:0]          resp_readdata,
  output logic [ADDR_W-1:0]          pio_address,
  output logic                       pio_chipselect,
  output logic                       pio_write_n,
  output logic [DATA_W-1:0]          pio_writedata,
  input  logic [DATA_W-1:0]          pio_readdata,
  output logic [PIO_OUT_W-1:0]       shadow_out,
  output logic                       busy
);
  localparam int PW = $clog2(NUM_REQ);

  arb_state_t           state_q, state_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]        own_q, own_d;
  logic                 wr_q, wr_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [DATA_W-1:0]    resp_q, resp_d;
  logic [PIO_OUT_W-1:0] shadow_q, shadow_d;

  logic [NUM_REQ-1:0]   gnt;
  logic [PW-1:0]        gnt_idx;
  logic                 gnt_any;
  logic [NUM_REQ-1:0]   own_oh;
  logic                 acc;

  rr_pick #(.NUM_REQ(NUM_REQ), .PW(PW)) u_pick (
    .req_i    (req_valid),
    .rr_ptr_i (rr_ptr_q),
    .gnt_o    (gnt),
    .idx_o    (gnt_idx),
    .any_o    (gnt_any)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    own_d    = own_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    data_d   = data_q;
    resp_d   = resp_q;
    shadow_d = shadow_q;
    unique case (state_q)
      IDLE: if (gnt_any) begin
        state_d = ACCESS;
        own_d   = gnt_idx;
        wr_d    = req_write[gnt_idx];
        addr_d  = req_address[int'(gnt_idx)*ADDR_W +: ADDR_W];
        data_d  = req_writedata[int'(gnt_idx)*DATA_W +: DATA_W];
      end
      ACCESS: begin
        state_d = RESP;
        resp_d  = wr_q ? '0 : pio_readdata;
        if (wr_q && addr_q == ADDR_W'(PIO_OUT_ADDR))
          shadow_d = data_q[PIO_OUT_W-1:0];
      end
      RESP: begin
        state_d  = IDLE;
        // Served requester drops to lowest priority.
        rr_ptr_d = (own_q == PW'(NUM_REQ-1)) ? '0 : own_q + PW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      own_q    <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      resp_q   <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      own_q    <= own_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      resp_q   <= resp_d;
      shadow_q <= shadow_d;
    end
  end

  always_comb begin
    own_oh        = '0;
    own_oh[own_q] = 1'b1;
  end

  assign acc            = (state_q == ACCESS);
  // Ready is held low during reset so no command is handshaken and then discarded.
  assign req_ready      = (state_q == IDLE && !reset) ? gnt : '0;
  assign resp_valid     = (state_q == RESP) ? own_oh : '0;
  assign resp_readdata  = (state_q == RESP) ? resp_q : '0;
  assign pio_chipselect = acc;
  assign pio_write_n    = ~(acc & wr_q);
  assign pio_address    = acc ? addr_q : '0;
  assign pio_writedata  = acc ? data_q : '0;
  assign shadow_out     = shadow_q;
  assign busy           = (state_q != IDLE);
endmodule

// File: tb/tb_pio_bus_arbiter.sv
// Directed bench for pio_bus_arbiter: stimulus pushes expected responses, a monitor pops and compares.
module tb_pio_bus_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        seed = 1'b1;
  logic [2:0]  req_valid = '0, req_write = '0;
  logic [5:0]  req_address = '0;
  logic [95:0] req_writedata = '0;
  logic [2:0]  req_ready, resp_valid;
  logic [31:0] resp_readdata, pio_writedata, pio_readdata;
  logic [1:0]  pio_address;
  logic        pio_chipselect, pio_write_n, busy;
  logic [3:0]  shadow_out;

  typedef struct {
    logic [2:0]  vld;
    logic [31:0] data;
  } exp_t;

  exp_t        sbq[$];
  exp_t        me;
  int          tests = 0, fails = 0, cyc = 0;
  logic [31:0] mem [4];

  pio_bus_arbiter #(.NUM_REQ(3), .DATA_W(32), .ADDR_W(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write),
    .req_address(req_address), .req_writedata(req_writedata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_readdata(resp_readdata),
    .pio_address(pio_address), .pio_chipselect(pio_chipselect),
    .pio_write_n(pio_write_n), .pio_writedata(pio_writedata),
    .pio_readdata(pio_readdata), .shadow_out(shadow_out), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // PIO slave model: combinational read, write on strobe
  assign pio_readdata = mem[pio_address];
  always @(posedge clk) begin
    if (seed) begin
      mem[0] <= 32'h0; mem[1] <= 32'h11; mem[2] <= 32'h22; mem[3] <= 32'h33;
    end else if (pio_chipselect && !pio_write_n) begin
      mem[pio_address] <= pio_writedata;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_req(input int i, input bit v, input bit w, input logic [1:0] a, input logic [31:0] d);
    req_valid[i] = v;
    req_write[i] = w;
    req_address[i*2 +: 2] = a;
    req_writedata[i*32 +: 32] = d;
  endtask

  task automatic push_exp(input int i, input logic [31:0] d);
    exp_t e;
    e.vld  = 3'(1 << i);
    e.data = d;
    sbq.push_back(e);
  endtask

  task automatic wait_accept(input string name, input logic [2:0] exp_rdy);
    bit got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (req_ready != 0) got = 1;
    end
    chk(name, req_ready, exp_rdy);
  endtask

  // Full single command; entered and left just after a posedge with the arbiter idle.
  task automatic do_cmd(input int i, input bit w, input logic [1:0] a, input logic [31:0] d,
                        input logic [31:0] rd, input logic [3:0] sh);
    push_exp(i, w ? 32'h0 : rd);
    set_req(i, 1, w, a, d);
    wait_accept("accept", 3'(1 << i));
    @(posedge clk); #1 set_req(i, 0, 0, 2'd0, 32'h0);
    @(negedge clk);
    chk("strobe_cs", pio_chipselect, 1);
    chk("strobe_wn", pio_write_n, !w);
    chk("strobe_addr", pio_address, a);
    chk("strobe_wdata", pio_writedata, d);
    @(negedge clk);
    chk("shadow", shadow_out, sh);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (resp_valid !== 3'b000) begin
      if (sbq.size() == 0) begin
        chk("resp_unexpected", resp_valid, 0);
      end else begin
        me = sbq.pop_front();
        chk("resp_valid", resp_valid, me.vld);
        chk("resp_data", resp_readdata, me.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int last;
    // Reset with all three requesters already pending
    set_req(0, 1, 0, 2'd1, 32'h0);
    set_req(1, 1, 0, 2'd2, 32'h0);
    set_req(2, 1, 0, 2'd3, 32'h0);
    repeat (2) @(posedge clk);
    #1 seed = 1'b0;
    @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_readdata, 0);
    chk("rst_cs", pio_chipselect, 0);
    chk("rst_wn", pio_write_n, 1);
    chk("rst_addr", pio_address, 0);
    chk("rst_wdata", pio_writedata, 0);
    chk("rst_shadow", shadow_out, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1 reset = 1'b0;

    // Fairness: 0,1,2,0,1,2 spaced 3 cycles apart
    for (int k = 0; k < 6; k++) push_exp(k % 3, 32'h11 * (k % 3 + 1));
    last = 0;
    for (int k = 0; k < 6; k++) begin
      wait_accept("rr_order", 3'(1 << (k % 3)));
      if (k > 0) chk("rr_spacing", cyc - last, 3);
      last = cyc;
    end
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk); @(negedge clk);
    @(posedge clk); #1;

    // Single write, read-back, non-zero address write
    do_cmd(1, 1, 2'd0, 32'h0000_000A, 32'h0, 4'hA);
    do_cmd(0, 0, 2'd0, 32'h0, 32'h0000_000A, 4'hA);
    do_cmd(1, 1, 2'd2, 32'h0000_0005, 32'h0, 4'hA);

    // Reset during the ACCESS strobe of a write of 3
    set_req(1, 1, 1, 2'd0, 32'h3);
    wait_accept("rstacc_accept", 3'b010);
    @(posedge clk); #1 set_req(1, 0, 0, 2'd0, 32'h0); reset = 1'b1;
    @(negedge clk);
    chk("rstacc_strobe", pio_chipselect, 1);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rstacc_ready", req_ready, 0);
    chk("rstacc_resp", resp_valid, 0);
    chk("rstacc_rdata", resp_readdata, 0);
    chk("rstacc_cs", pio_chipselect, 0);
    chk("rstacc_wn", pio_write_n, 1);
    chk("rstacc_addr", pio_address, 0);
    chk("rstacc_wdata", pio_writedata, 0);
    chk("rstacc_shadow", shadow_out, 0);
    chk("rstacc_busy", busy, 0);
    @(posedge clk); #1;
    push_exp(0, 32'h11);
    push_exp(2, 32'h33);
    set_req(0, 1, 0, 2'd1, 32'h0);
    set_req(2, 1, 0, 2'd3, 32'h0);
    wait_accept("rstacc_ptr0", 3'b001);
    @(posedge clk); #1 set_req(0, 0, 0, 2'd0, 32'h0);
    wait_accept("rstacc_next", 3'b100);
    @(posedge clk); #1 set_req(2, 0, 0, 2'd0, 32'h0);
    @(negedge clk); @(negedge clk);
    @(posedge clk); #1;

    // Withdrawn request: requester 2 pulses valid only while requester 0 is in flight
    push_exp(0, 32'h3);
    set_req(0, 1, 0, 2'd0, 32'h0);
    wait_accept("wd_accept", 3'b001);
    @(posedge clk); #1 set_req(0, 0, 0, 2'd0, 32'h0); set_req(2, 1, 1, 2'd2, 32'h7);
    @(negedge clk);
    chk("wd_ready_acc", req_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wd_ready_resp", req_ready, 0);
    @(posedge clk); #1 set_req(2, 0, 0, 2'd0, 32'h0);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("wd_no_ready", req_ready, 0);
      chk("wd_no_strobe", pio_chipselect, 0);
    end

    chk("sb_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
